sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Central sequencer for the SDRAM controller. It owns the single SDRAM command/address bus and a refresh-interval timer. It grants the bus to exactly one of four engines (init, auto-refresh, write, read) at a time, with fixed priority refresh > write > read. It sits between the engines and the SDRAM pins, and generates the `aref_req` that the write and read engines use to break bursts.

## Interface
Parameters:
- `REF_PERIOD`, 780: cycles between refresh requests (7.8 µs at 100 MHz).
- `BANK`, 2'b00: constant bank address driven on `sdram_ba`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flag_init_end` in 1: init engine done; stays high after first assertion.
- `init_cmd` in 4 / `init_addr` in 13: init engine command/address.
- `flag_ref_end` in 1: one-cycle pulse; refresh engine done.
- `ref_cmd` in 4 / `ref_addr` in 13: refresh engine command/address.
- `wr_req` in 1 / `flag_wr_end` in 1: write engine request (level) / done pulse.
- `wr_cmd` in 4 / `wr_addr` in 13: write engine command/address.
- `rd_req` in 1 / `flag_rd_end` in 1: read engine request (level) / done pulse.
- `rd_cmd` in 4 / `rd_addr` in 13: read engine command/address.
- `aref_req` out 1: refresh due; goes to the refresh, write and read engines.
- `aref_en` out 1: one-cycle grant pulse to the refresh engine.
- `wr_en` out 1: one-cycle grant pulse to the write engine.
- `rd_en` out 1: one-cycle grant pulse to the read engine.
- `aref_overrun` out 1: sticky error flag; a refresh period expired while the previous request was still pending.
- `sdram_cke` out 1: clock enable; 1 after reset.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: the selected 4-bit command `{cs_n,ras_n,cas_n,we_n}`.
- `sdram_ba` out 2: always `BANK`.
- `sdram_addr` out 13: selected address.

## Operation
- States: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ. Encoding is one-hot; reset state is S_INIT.
- S_INIT goes to S_ARBIT when `flag_init_end`=1.
- S_ARBIT selects the next state by priority:
  - `aref_req`=1 → S_AREF
  - else `wr_req`=1 → S_WRITE
  - else `rd_req`=1 → S_READ
  - else stay in S_ARBIT.
- Exits: S_AREF → S_ARBIT on `flag_ref_end`; S_WRITE → S_ARBIT on `flag_wr_end`; S_READ → S_ARBIT on `flag_rd_end`. Requests are ignored outside S_ARBIT.
- Grant pulses: `aref_en`, `wr_en` and `rd_en` are registered. Each is high for exactly the first cycle `state_c` holds the matching state.
- Command mux is combinational from `state_c`:
  - S_INIT → init_*
  - S_AREF → ref_*
  - S_WRITE → wr_*
  - S_READ → rd_*
  - S_ARBIT → NOP (4'b0111) with addr 13'h0400.
- Refresh timer:
  - Held at 0 until `flag_init_end`; then counts 0..`REF_PERIOD`-1 and wraps.
  - `aref_req` is set on the cycle after the counter equals `REF_PERIOD`-1.
  - `aref_req` clears on the cycle after `aref_en`.
  - If the counter wraps while `aref_req` is already 1, `aref_req` stays 1 and `aref_overrun` is set. Only reset clears `aref_overrun`.
- Simultaneous events:
  - A done pulse and a new request in the same cycle: the FSM goes to S_ARBIT first and arbitrates on the next cycle. This gives a minimum of one NOP cycle between owners.
  - `aref_req` and `wr_req` in S_ARBIT: refresh wins.
- Reset mid-operation: every register returns to its reset value immediately, including any in-progress grant.

## Timing
- Reset values:
  - state S_INIT
  - `aref_req`, `aref_en`, `wr_en`, `rd_en`, `aref_overrun` = 0
  - timer = 0
  - `sdram_cke`=1, `sdram_ba`=`BANK`
  - cmd/addr = init_cmd/init_addr (pass-through).
- Grant latency: a request seen in S_ARBIT at edge N gives the new state and enable pulse at edge N+1. The engine's own command follows at the earliest at N+2.
- Release latency: a done pulse at edge N gives S_ARBIT and NOP at N+1.
- Refresh spacing: `aref_req` rises exactly every `REF_PERIOD` cycles, independent of bus occupancy.

## Structure
- Shared package `sdram_pkg` holds:
  - command constants CMD_NOP, CMD_PALL, CMD_AREF, CMD_ACT, CMD_WRITE, CMD_READ, CMD_MRS
  - the 13-bit constant A10_ONLY = 13'h0400
  - the arbiter state encodings.
- One sub-module, `sdram_aref_timer`:
  - owns the counter, `aref_req` and `aref_overrun`
  - inputs: `clk`, `rst_n`, `flag_init_end`, `aref_en`.

## Test plan
- Init handoff: hold `flag_init_end`=0 for 200 cycles, and check outputs equal init_cmd/init_addr. Raise it, and check S_ARBIT plus NOP/13'h0400 on the next cycle and the timer starting at 0.
- Refresh period: with `REF_PERIOD`=16 and no write/read traffic, check `aref_req` rises 16 cycles after init end, `aref_en` pulses one cycle later, and `aref_req` clears one cycle after that. Return `flag_ref_end` 8 cycles later and check the cycle after it is NOP.
- Priority: assert `wr_req`, `rd_req` and `aref_req` together in S_ARBIT. Check the grant order is aref, then write, then read, with each `*_en` exactly one cycle wide.
- Mid-read refresh: during S_READ, raise `aref_req` and make the read engine pulse `flag_rd_end` and keep `rd_req`. Check the next grant is S_AREF, then S_READ resumes.
- Overrun: with `REF_PERIOD`=16, hold S_WRITE for 40 cycles. Check `aref_overrun`=1 at cycle 32 and that it stays 1. Assert `rst_n`=0 mid-write and check all reset values.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// the A10-only address used with NOP/PALL, and the one-hot arbiter states.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PALL  = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [12:0] A10_ONLY = 13'h0400;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } arb_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// Refresh-interval timer: raises aref_req once per REF_PERIOD cycles after init,
// holds it until the refresh engine is granted, and flags missed refreshes.
module sdram_aref_timer
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flag_init_end,
    input  logic aref_en,
    output logic aref_req,
    output logic aref_overrun
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REF_PERIOD - 1);

    logic          run_reg;
    logic [CW-1:0] cnt_reg;
    logic          aref_req_reg;
    logic          overrun_reg;
    logic          wrap;

    // run_reg delays the start by one cycle so the counter reads 0 in the
    // first cycle after init completes and the first request lands REF_PERIOD later.
    assign wrap = run_reg && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg      <= 1'b0;
            cnt_reg      <= '0;
            aref_req_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            run_reg <= flag_init_end;
            if (!run_reg || wrap) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (wrap) begin
                aref_req_reg <= 1'b1;
            end else if (aref_en) begin
                aref_req_reg <= 1'b0;
            end
            if (wrap && aref_req_reg && !aref_en) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign aref_req     = aref_req_reg;
    assign aref_overrun = overrun_reg;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: grants the command/address bus to init, refresh, write or
// read engine (refresh > write > read) and muxes the owner's command onto the pins.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int         REF_PERIOD = 780,
    parameter logic [1:0] BANK       = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        flag_ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [12:0] ref_addr,
    input  logic        wr_req,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic        rd_req,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    output logic        aref_req,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        aref_overrun,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr
);

    arb_state_t  state_c;
    arb_state_t  state_n;
    logic        aref_en_reg;
    logic        wr_en_reg;
    logic        rd_en_reg;
    logic [3:0]  bus_cmd;
    logic [12:0] bus_addr;

    sdram_aref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .flag_init_end (flag_init_end),
        .aref_en       (aref_en_reg),
        .aref_req      (aref_req),
        .aref_overrun  (aref_overrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_c <= S_INIT;
        end else begin
            state_c <= state_n;
        end
    end

    // Every owner returns to S_ARBIT before the next grant, so a done pulse
    // coinciding with a new request always costs one NOP cycle.
    always_comb begin
        state_n = state_c;
        unique case (state_c)
            S_INIT:  if (flag_init_end) state_n = S_ARBIT;
            S_ARBIT: begin
                if (aref_req) begin
                    state_n = S_AREF;
                end else if (wr_req) begin
                    state_n = S_WRITE;
                end else if (rd_req) begin
                    state_n = S_READ;
                end
            end
            S_AREF:  if (flag_ref_end) state_n = S_ARBIT;
            S_WRITE: if (flag_wr_end)  state_n = S_ARBIT;
            S_READ:  if (flag_rd_end)  state_n = S_ARBIT;
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aref_en_reg <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
        end else begin
            aref_en_reg <= (state_n == S_AREF)  && (state_c != S_AREF);
            wr_en_reg   <= (state_n == S_WRITE) && (state_c != S_WRITE);
            rd_en_reg   <= (state_n == S_READ)  && (state_c != S_READ);
        end
    end

    always_comb begin
        bus_cmd  = CMD_NOP;
        bus_addr = A10_ONLY;
        unique case (state_c)
            S_INIT: begin
                bus_cmd  = init_cmd;
                bus_addr = init_addr;
            end
            S_AREF: begin
                bus_cmd  = ref_cmd;
                bus_addr = ref_addr;
            end
            S_WRITE: begin
                bus_cmd  = wr_cmd;
                bus_addr = wr_addr;
            end
            S_READ: begin
                bus_cmd  = rd_cmd;
                bus_addr = rd_addr;
            end
            default: begin
                bus_cmd  = CMD_NOP;
                bus_addr = A10_ONLY;
            end
        endcase
    end

    assign aref_en     = aref_en_reg;
    assign wr_en       = wr_en_reg;
    assign rd_en       = rd_en_reg;
    assign sdram_cke   = 1'b1;
    assign sdram_ba    = BANK;
    assign sdram_cs_n  = bus_cmd[3];
    assign sdram_ras_n = bus_cmd[2];
    assign sdram_cas_n = bus_cmd[1];
    assign sdram_we_n  = bus_cmd[0];
    assign sdram_addr  = bus_addr;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant expectations are queued when requests are
// driven and popped when a grant pulse appears; bus and refresh timing checked inline.
module tb_sdram_arbiter;

    localparam int         P    = 16;
    localparam logic [1:0] BANK = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag_init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0010;
    logic [12:0] init_addr = 13'h1ABC;
    logic        flag_ref_end = 1'b0;
    logic [3:0]  ref_cmd = 4'b0001;
    logic [12:0] ref_addr = 13'h0111;
    logic        wr_req = 1'b0;
    logic        flag_wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0100;
    logic [12:0] wr_addr = 13'h0A22;
    logic        rd_req = 1'b0;
    logic        flag_rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0101;
    logic [12:0] rd_addr = 13'h1333;
    logic        aref_req, aref_en, wr_en, rd_en, aref_overrun;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    sdram_arbiter #(
        .REF_PERIOD (P),
        .BANK       (BANK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flag_init_end (flag_init_end),
        .init_cmd      (init_cmd),
        .init_addr     (init_addr),
        .flag_ref_end  (flag_ref_end),
        .ref_cmd       (ref_cmd),
        .ref_addr      (ref_addr),
        .wr_req        (wr_req),
        .flag_wr_end   (flag_wr_end),
        .wr_cmd        (wr_cmd),
        .wr_addr       (wr_addr),
        .rd_req        (rd_req),
        .flag_rd_end   (flag_rd_end),
        .rd_cmd        (rd_cmd),
        .rd_addr       (rd_addr),
        .aref_req      (aref_req),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .aref_overrun  (aref_overrun),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_pass = 0;
    int         n_total = 0;
    int         t_rise0 = 0;
    logic [2:0] sb[$];
    logic [3:0] bus_cmd;

    assign bus_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [16:0] owner_bus(input logic [2:0] g);
        case (g)
            3'b100:  return {ref_cmd, ref_addr};
            3'b010:  return {wr_cmd, wr_addr};
            3'b001:  return {rd_cmd, rd_addr};
            default: return {4'b0111, 13'h0400};
        endcase
    endfunction

    // Pops the next expected grant, waits up to limit edges for any enable pulse,
    // then checks which engine got it, the bus owner and the one-cycle pulse width.
    task automatic expect_grant(input string tag, input int limit);
        logic [2:0] exp_g;
        bit         found;
        found = 1'b0;
        exp_g = sb.pop_front();
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            found = aref_en | wr_en | rd_en;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        check({tag, "_en"}, {aref_en, wr_en, rd_en}, exp_g);
        check({tag, "_bus"}, {bus_cmd, sdram_addr}, owner_bus(exp_g));
        tick();
        check({tag, "_width"}, {aref_en, wr_en, rd_en}, 3'b000);
    endtask

    task automatic wait_aref(input string tag, input int limit);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            found = aref_req;
        end
        check({tag, "_rise"}, 32'(found), 32'd1);
        check({tag, "_phase"}, 32'((cyc - t_rise0) % P), 32'd0);
    endtask

    task automatic pulse_done(input string tag, input int which);
        case (which)
            0:       flag_ref_end = 1'b1;
            1:       flag_wr_end  = 1'b1;
            default: flag_rd_end  = 1'b1;
        endcase
        tick();
        flag_ref_end = 1'b0;
        flag_wr_end  = 1'b0;
        flag_rd_end  = 1'b0;
        check({tag, "_nop"}, {bus_cmd, sdram_addr}, {4'b0111, 13'h0400});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_aref_req"}, 32'(aref_req), 32'd0);
        check({tag, "_en"}, {aref_en, wr_en, rd_en}, 3'b000);
        check({tag, "_overrun"}, 32'(aref_overrun), 32'd0);
        check({tag, "_cke"}, 32'(sdram_cke), 32'd1);
        check({tag, "_ba"}, sdram_ba, BANK);
        check({tag, "_bus"}, {bus_cmd, sdram_addr}, {init_cmd, init_addr});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_reset("rst0");
        rst_n = 1'b1;

        // Init handoff: init engine owns the bus while flag_init_end is low
        for (int k = 0; k < 4; k++) begin
            init_cmd  = 4'($urandom_range(0, 15));
            init_addr = 13'($urandom_range(0, 8191));
            repeat (50) tick();
            check($sformatf("init_bus%0d", k), {bus_cmd, sdram_addr}, {init_cmd, init_addr});
            check($sformatf("init_noreq%0d", k), 32'(aref_req), 32'd0);
        end
        flag_init_end = 1'b1;
        tick();
        check("init_to_arbit", {bus_cmd, sdram_addr}, {4'b0111, 13'h0400});

        // First refresh request exactly P cycles after init end
        repeat (P - 1) tick();
        check("aref_early", 32'(aref_req), 32'd0);
        tick();
        check("aref_first", 32'(aref_req), 32'd1);
        t_rise0 = cyc;
        sb.push_back(3'b100);
        expect_grant("ref0", 1);
        check("aref_clear", 32'(aref_req), 32'd0);
        repeat (6) tick();
        pulse_done("ref0", 0);

        // Priority: refresh, write and read all pending in S_ARBIT
        wait_aref("pri", 2 * P);
        wr_req = 1'b1;
        rd_req = 1'b1;
        sb.push_back(3'b100);
        sb.push_back(3'b010);
        sb.push_back(3'b001);
        expect_grant("pri_aref", 1);
        pulse_done("pri_aref", 0);
        expect_grant("pri_wr", 1);
        wr_req = 1'b0;
        pulse_done("pri_wr", 1);
        expect_grant("pri_rd", 1);
        rd_req = 1'b0;
        pulse_done("pri_rd", 2);

        // Mid-read refresh: read breaks its burst, refresh runs, read resumes
        rd_req = 1'b1;
        sb.push_back(3'b001);
        expect_grant("mr_rd", 1);
        wait_aref("mr", 2 * P);
        sb.push_back(3'b100);
        sb.push_back(3'b001);
        pulse_done("mr_rd", 2);
        expect_grant("mr_aref", 1);
        pulse_done("mr_aref", 0);
        expect_grant("mr_rd2", 1);
        rd_req = 1'b0;
        pulse_done("mr_rd2", 2);

        // Overrun: a long write keeps the refresh request pending past a wrap
        wr_req = 1'b1;
        sb.push_back(3'b010);
        expect_grant("ov_wr", 1);
        wait_aref("ov", 2 * P);
        check("ov_none_at_rise", 32'(aref_overrun), 32'd0);
        repeat (P - 1) tick();
        check("ov_none_before_wrap", 32'(aref_overrun), 32'd0);
        tick();
        check("ov_set", 32'(aref_overrun), 32'd1);
        check("ov_req_held", 32'(aref_req), 32'd1);
        repeat (16) tick();
        check("ov_sticky", 32'(aref_overrun), 32'd1);
        check("ov_still_write", {bus_cmd, sdram_addr}, {wr_cmd, wr_addr});

        // Asynchronous reset in the middle of the write
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        tick();
        tick();
        check_reset("rst_hold");
        rst_n = 1'b1;
        tick();
        check("post_rst_arbit", {bus_cmd, sdram_addr}, {4'b0111, 13'h0400});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
